alu_multicycle: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU.
- Adds a valid/ready handshake on both sides, chunked multi-cycle add/sub (carry rippled one CHUNK per clock), an extended 3-bit opcode set and a full NZCV flag set.
- Sits between register-file read and writeback in the sequential core; the core stalls on in_ready/out_valid.
- Opcodes 0-3 keep the legacy encoding (add, sub, and, xor).

---
 rtl/alu_multicycle.sv | 165 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshakes on both sides. Logic ops finish
// in one clock. Add, sub and slt ripple the carry through the operands one
// CHUNK per clock. Every completion updates a full NZCV flag set.
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject chunk sizes that do not tile the operand exactly.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("alu_multicycle: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARITH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     k;          // chunk being added this clock
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;        // effective B: b for add, ~b for sub/slt
  logic [WIDTH-1:0]  sum_q;      // partial sum built up chunk by chunk
  logic              carry;

  logic              is_arith;
  logic              last_chunk;
  logic [CHUNK:0]    chunk_sum;
  logic [WIDTH-1:0]  sum_next;
  logic [WIDTH-1:0]  arith_res;
  logic [WIDTH-1:0]  logic_res;
  logic              v_arith;
  logic              lt;

  assign is_arith   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  assign last_chunk = (k == CW'(NCHUNK - 1));

  // One chunk of the ripple adder plus the final result and overflow selection.
  always_comb begin
    // NOTE: every variable written here gets a value first, so no path can
    // leave it unassigned and infer a latch.
    chunk_sum = {1'b0, a_q[k*CHUNK +: CHUNK]} + {1'b0, b_q[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    sum_next  = sum_q;
    sum_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Only used on the last chunk, when sum_next holds the complete sum.
    v_arith   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);
    lt        = sum_next[WIDTH-1] ^ v_arith;
    arith_res = (op_q == OP_SLT) ? WIDTH'(lt) : sum_next;
  end

  // Single-cycle logic ops, computed straight from the request inputs.
  always_comb begin
    logic_res = '0;
    case (op)
      OP_AND:  logic_res = a & b;
      OP_XOR:  logic_res = a ^ b;
      OP_OR:   logic_res = a | b;
      OP_NOT:  logic_res = ~a;
      default: logic_res = b;        // pass b; arith codes never reach DONE this way
    endcase
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_next = is_arith ? ARITH : DONE;
      ARITH:   if (last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand latch, chunked adder registers, and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k      <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= (op == OP_ADD) ? b : ~b;
            carry <= is_arith && (op != OP_ADD);
            sum_q <= '0;
            k     <= '0;
            if (!is_arith) begin
              result <= logic_res;
              flag_n <= logic_res[WIDTH-1];
              flag_z <= (logic_res == '0);
              flag_c <= 1'b0;
              flag_v <= 1'b0;
            end
          end
        end
        ARITH: begin
          sum_q <= sum_next;
          carry <= chunk_sum[CHUNK];
          if (last_chunk) begin
            k      <= '0;
            result <= arith_res;
            flag_n <= arith_res[WIDTH-1];
            flag_z <= (arith_res == '0);
            flag_c <= chunk_sum[CHUNK];
            flag_v <= v_arith;
          end else begin
            k <= k + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, hand-written
// handshake/reset sequences, a chunk-size sweep and random ops against a model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [63:0] a, b;

  logic        in_ready, out_valid, flag_n, flag_z, flag_c, flag_v;
  logic [63:0] result;

  logic        s1_in_ready, s1_out_valid, s1_n, s1_z, s1_c, s1_v;
  logic [63:0] s1_result;
  logic        s2_in_ready, s2_out_valid, s2_n, s2_z, s2_c, s2_v;
  logic [63:0] s2_result;
  logic        s3_in_ready, s3_out_valid, s3_n, s3_z, s3_c, s3_v;
  logic [31:0] s3_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v));

  alu_multicycle #(.WIDTH(64), .CHUNK(64)) dut_c64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready), .op(op),
    .a(a), .b(b), .out_valid(s1_out_valid), .out_ready(out_ready), .result(s1_result),
    .flag_n(s1_n), .flag_z(s1_z), .flag_c(s1_c), .flag_v(s1_v));

  alu_multicycle #(.WIDTH(64), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s2_in_ready), .op(op),
    .a(a), .b(b), .out_valid(s2_out_valid), .out_ready(out_ready), .result(s2_result),
    .flag_n(s2_n), .flag_z(s2_z), .flag_c(s2_c), .flag_v(s2_v));

  alu_multicycle #(.WIDTH(32), .CHUNK(4)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s3_in_ready), .op(op),
    .a(a[31:0]), .b(b[31:0]), .out_valid(s3_out_valid), .out_ready(out_ready),
    .result(s3_result), .flag_n(s3_n), .flag_z(s3_z), .flag_c(s3_c), .flag_v(s3_v));

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  nzcv;
    int          lat;   // edges after the accept edge until out_valid is seen
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [64:0] s;
    logic [63:0] r, yb;
    logic        c, v;
    c = 1'b0; v = 1'b0; r = '0; s = '0; yb = '0;
    case (o)
      3'd0, 3'd1, 3'd6: begin
        yb = (o == 3'd0) ? y : ~y;
        s  = {1'b0, x} + {1'b0, yb} + 65'(o != 3'd0);
        c  = s[64];
        v  = (x[63] == yb[63]) && (s[63] != x[63]);
        r  = (o == 3'd6) ? 64'($signed(x) < $signed(y)) : s[63:0];
      end
      3'd2:    r = x & y;
      3'd3:    r = x ^ y;
      3'd4:    r = x | y;
      3'd5:    r = ~x;
      default: r = y;
    endcase
    return {r, r[63], (r == 64'd0), c, v};
  endfunction

  function automatic logic [67:0] dut_out();
    return {result, flag_n, flag_z, flag_c, flag_v};
  endfunction

  // Wait for in_ready, issue one request, then wait for out_valid.
  task automatic issue(input logic [2:0] o, input logic [63:0] aa, input logic [63:0] bb,
                       output int lat, output int busy_ready);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_wait", 68'(in_ready), 68'(1));
    op = o; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy_ready = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) busy_ready++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy, n, cnt;
    int l1, l2, l3, l0;
    logic [67:0] r1, r2, r3;
    logic seen;
    logic [2:0]  ro;
    logic [63:0] ra, rb;

    vecs[0]  = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,                  4'b0110, 4, "add_carry_chain"};
    vecs[1]  = '{3'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 4, "sub_overflow"};
    vecs[2]  = '{3'd1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE,                   4'b1000, 4, "sub_borrow"};
    vecs[3]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd1,                   4'b0010, 4, "slt_true"};
    vecs[4]  = '{3'd6, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                   4'b0100, 4, "slt_false"};
    vecs[5]  = '{3'd3, 64'hF0F0, 64'hFF00, 64'h0FF0,                             4'b0000, 0, "xor"};
    vecs[6]  = '{3'd5, 64'd0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF,                 4'b1000, 0, "not_a"};
    vecs[7]  = '{3'd2, 64'hFF00, 64'h0F0F, 64'h0F00,                             4'b0000, 0, "and"};
    vecs[8]  = '{3'd4, 64'hF000_0000_0000_0000, 64'd1, 64'hF000_0000_0000_0001,  4'b1000, 0, "or"};
    vecs[9]  = '{3'd7, 64'd5, 64'd0, 64'd0,                                      4'b0100, 0, "pass_b"};
    vecs[10] = '{3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000,  4'b1001, 4, "add_overflow"};
    vecs[11] = '{3'd0, 64'd2, 64'd3, 64'd5,                                      4'b0000, 4, "add_small"};
    vecs[12] = '{3'd1, 64'd5, 64'd5, 64'd0,                                      4'b0110, 4, "sub_equal"};

    // Reset state, and a request on the last reset edge is dropped.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, result, flag_n, flag_z}, {1'b1, 1'b0, 64'd0, 2'b00});
    check("reset_flags", 68'({flag_c, flag_v}), 68'(0));
    op = 3'd3; a = 64'd1; b = 64'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("req_at_reset_release", 68'({in_ready, out_valid}), 68'(2'b10));
    @(posedge clk); #1;
    check("req_at_reset_release_2", 68'(out_valid), 68'(0));

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy);
      check({vecs[i].name, "_lat"}, 68'(lat), 68'(vecs[i].lat));
      check({vecs[i].name, "_res"}, dut_out(), {vecs[i].res, vecs[i].nzcv});
      check({vecs[i].name, "_busy"}, 68'(busy), 68'(0));
    end

    // Backpressure: result held while out_ready is low; requests ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(3'd0, 64'd2, 64'd3, lat, busy);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {out_valid, in_ready, dut_out()}, {1'b1, 1'b0, 64'd5, 4'b0000});
      op = 3'd3; a = 64'hFF; b = 64'h0F; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_hold_end", {out_valid, dut_out()}, {1'b1, 64'd5, 4'b0000});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {in_ready, out_valid, dut_out()}, {1'b1, 1'b0, 64'd5, 4'b0000});

    // Reset during ARITH chunk 2 drops the operation.
    op = 3'd0; a = 64'd1; b = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_reset_state", {in_ready, out_valid, dut_out()}, {1'b1, 1'b0, 64'd0, 4'b0000});
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("mid_reset_no_valid", 68'(seen), 68'(0));
    issue(3'd0, 64'd7, 64'd8, lat, busy);
    check("after_reset_lat", 68'(lat), 68'(4));
    check("after_reset_res", dut_out(), {64'd15, 4'b0000});

    // Chunk-size sweep: same carry-chain add on every instance.
    @(posedge clk); #1;
    n = 0;
    while (!(in_ready && s1_in_ready && s2_in_ready && s3_in_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("sweep_idle", 68'({in_ready, s1_in_ready, s2_in_ready, s3_in_ready}), 68'(4'hF));
    op = 3'd0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l0 = -1; l1 = -1; l2 = -1; l3 = -1; r1 = '0; r2 = '0; r3 = '0;
    for (cnt = 0; cnt <= 16; cnt++) begin
      if (out_valid && l0 < 0) l0 = cnt;
      if (s1_out_valid && l1 < 0) begin l1 = cnt; r1 = {s1_result, s1_n, s1_z, s1_c, s1_v}; end
      if (s2_out_valid && l2 < 0) begin l2 = cnt; r2 = {s2_result, s2_n, s2_z, s2_c, s2_v}; end
      if (s3_out_valid && l3 < 0) begin l3 = cnt; r3 = 68'({s3_result, s3_n, s3_z, s3_c, s3_v}); end
      @(posedge clk); #1;
    end
    check("sweep_c16_lat", 68'(l0), 68'(4));
    check("sweep_c64_lat", 68'(l1), 68'(1));
    check("sweep_c8_lat",  68'(l2), 68'(8));
    check("sweep_w32_lat", 68'(l3), 68'(8));
    check("sweep_c64_res", r1, {64'd0, 4'b0110});
    check("sweep_c8_res",  r2, {64'd0, 4'b0110});
    check("sweep_w32_res", r3, 68'({32'd0, 4'b0110}));

    // Random ops against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 4 == 1) rb = ra;
      if (i % 8 == 3) rb = 64'($urandom_range(0, 3));
      issue(ro, ra, rb, lat, busy);
      check("random", dut_out(), model(ro, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
